decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Consumer end of the IF_ID pipeline interface. Accepts the 64-bit {pc, instruction} word from fetch. Decodes the instruction fields, reads a 32x32 register file with write-back bypass, and detects load-use hazards. Drives the ID_EX pipeline register toward execute under a valid/ready handshake, back-pressuring fetch when stalled.

Parameters:
NREGS, 32, register file depth (address width 5; fixed)
LOAD_OPCODE, 7'b0000011, opcode value classed as a load
PC_W, 32, pc width carried from IF_ID[63:32]

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low; clock clock (reset asserted when 0 at posedge)
IF_ID  in  64  [31:0]=instruction, [63:32]=pc
if_valid  in  1  IF_ID holds a valid instruction this cycle
if_ready  out  1  decode accepts IF_ID this cycle (combinational)
wb_en  in  1  register write-back enable
wb_addr  in  5  write-back register index
wb_data  in  32  write-back data
ex_ready  in  1  execute accepts ID_EX this cycle
ID_EX  out  144  registered: [31:0] pc, [63:32] rs1_val, [95:64] rs2_val, [127:96] imm, [132:128] rd, [135:133] funct3, [142:136] opcode, [143] is_load
id_valid  out  1  ID_EX holds a valid decoded instruction
stall_count  out  32  number of load-use bubble cycles inserted since reset

Behaviour:
- Field extraction from instr = IF_ID[31:0]:
  - opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20].
  - imm = sign-extended instr[31:20] (I-type only; no other formats).
  - is_load = (opcode==LOAD_OPCODE).
- Register file: 32 entries x 32 bits.
  - Written at posedge when wb_en && wb_addr!=0.
  - x0 always reads 0, and writes to x0 are ignored.
- Read bypass: if wb_en && wb_addr!=0 && wb_addr==rsN, rsN_val = wb_data (same-cycle write visible to decode).
- Hazard (combinational): hazard = id_valid && ID_EX[143] && ID_EX[132:128]!=0 && (ID_EX rd == rs1 || ID_EX rd == rs2). rs1/rs2 are taken from the current IF_ID. Evaluated regardless of if_valid; gated by if_valid only at transfer.
- advance = !id_valid || ex_ready.
- if_ready = advance && !hazard.
- Accept = if_valid && if_ready.
- Posedge update, when advance:
  - If Accept: ID_EX <= decoded fields; id_valid <= 1.
  - Else if if_valid && hazard: insert bubble. id_valid <= 0, ID_EX unchanged, stall_count += 1.
  - Else: id_valid <= 0.
- When !advance: ID_EX and id_valid hold. No stall_count increment while held, even if a hazard is present.
- A bubble lasts exactly one cycle. The next cycle id_valid=0, so hazard=0 and the dependent instruction is accepted.
- stall_count wraps 0xFFFFFFFF -> 0.
- Reset (reset==0 at posedge):
  - id_valid=0, ID_EX=0, stall_count=0, all 32 registers cleared to 0.
  - Reset overrides a simultaneous wb_en write and any in-flight transfer.
  - if_ready during reset is don't-care; fetch is also held.
- Latency: IF_ID accepted at edge N appears on ID_EX/id_valid after edge N (one cycle).
- Throughput: one instruction per cycle when no hazard and ex_ready=1.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wb_en=1, wb_addr=5 -> id_valid=0, ID_EX=0, stall_count=0. A subsequent read of x5 returns 0.
- Decode and imm sign extension: write x1=0x00000010. Present pc=0x4, instr=0xFFF08093 (opcode 0x13, rd=1, rs1=1, imm=-1) -> next cycle ID_EX pc=0x4, rs1_val=0x10, imm=0xFFFFFFFF, rd=1, funct3=0, is_load=0, id_valid=1.
- Bypass and x0: instr reads rs1=3 while wb_en=1, wb_addr=3, wb_data=0xDEADBEEF in the same cycle -> rs1_val=0xDEADBEEF. A write of 0x55 to x0 -> later x0 reads 0.
- Load-use: accept load 0x00002183 (rd=3), then present 0x00018213 (rs1=3), ex_ready=1 -> one cycle if_ready=0 and id_valid=0, stall_count=1. The cycle after, the dependent instruction is accepted and id_valid=1.
- Back-pressure: ex_ready=0 with id_valid=1 for 3 cycles -> ID_EX stable, if_ready=0, stall_count unchanged. With ex_ready=1 the held instruction transfers and the next is accepted.
- Reset mid-stream: reset=0 during a load-use stall -> id_valid=0, stall_count=0 next cycle. Decode resumes cleanly after reset=1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: consumer end of the IF_ID pipeline interface.
// Decodes the fetched instruction, reads a 32x32 register file with
// write-back bypass, detects load-use hazards and drives the registered
// ID_EX word toward execute under a valid/ready handshake.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   IF_ID        {pc[63:32], instruction[31:0]} from fetch
//   if_valid     IF_ID holds a valid instruction
//   if_ready     decode accepts IF_ID this cycle (combinational)
//   wb_en        register write-back enable
//   wb_addr      write-back register index
//   wb_data      write-back data
//   ex_ready     execute accepts ID_EX this cycle
//   ID_EX        registered decoded word (pc, rs1_val, rs2_val, imm, rd,
//                funct3, opcode, is_load from LSB to MSB)
//   id_valid     ID_EX holds a valid decoded instruction
//   stall_count  load-use bubble cycles inserted since reset (wraps)
module decode_stage #(
  parameter int unsigned NREGS       = 32,
  parameter logic [6:0]  LOAD_OPCODE = 7'b0000011,
  parameter int unsigned PC_W        = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [63:0]   IF_ID,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          ex_ready,
  output logic [143:0]  ID_EX,
  output logic          id_valid,
  output logic [31:0]   stall_count
);

  logic [31:0]     regs_q [NREGS];
  logic [31:0]     regs_d [NREGS];
  logic [143:0]    id_ex_q, id_ex_d;
  logic            id_valid_q, id_valid_d;
  logic [31:0]     stall_count_q, stall_count_d;

  logic [31:0]     instr;
  logic [PC_W-1:0] pc;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [31:0]     imm;
  logic            is_load;
  logic [31:0]     rs1_val, rs2_val;
  logic            wb_write;
  logic            hazard, advance, accept;

  assign instr   = IF_ID[31:0];
  assign pc      = IF_ID[32 +: PC_W];
  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign imm     = {{20{instr[31]}}, instr[31:20]};
  assign is_load = (opcode == LOAD_OPCODE);

  assign wb_write = wb_en && (wb_addr != '0);

  // x0 is never written, so regs_q[0] stays zero; the explicit zero check
  // keeps a same-cycle write to x0 from leaking through the bypass.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = (wb_write && wb_addr == rs1) ? wb_data : regs_q[rs1];
    if (rs2 != '0) rs2_val = (wb_write && wb_addr == rs2) ? wb_data : regs_q[rs2];
  end

  // Hazard looks at the current IF_ID regardless of if_valid; if_valid only
  // gates the transfer and the bubble count.
  assign hazard   = id_valid_q && id_ex_q[143] && (id_ex_q[132:128] != '0) &&
                    ((id_ex_q[132:128] == rs1) || (id_ex_q[132:128] == rs2));
  assign advance  = !id_valid_q || ex_ready;
  assign if_ready = advance && !hazard;
  assign accept   = if_valid && if_ready;

  always_comb begin
    regs_d = regs_q;
    if (wb_write) regs_d[wb_addr] = wb_data;
  end

  always_comb begin
    id_ex_d       = id_ex_q;
    id_valid_d    = id_valid_q;
    stall_count_d = stall_count_q;
    if (advance) begin
      id_valid_d = 1'b0;
      if (accept) begin
        id_ex_d    = {is_load, opcode, funct3, rd, imm, rs2_val, rs1_val, pc};
        id_valid_d = 1'b1;
      end else if (if_valid && hazard) begin
        stall_count_d = stall_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      regs_q        <= '{default: '0};
      id_ex_q       <= '0;
      id_valid_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      regs_q        <= regs_d;
      id_ex_q       <= id_ex_d;
      id_valid_q    <= id_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ID_EX       = id_ex_q;
  assign id_valid    = id_valid_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed, table-driven bench for decode_stage.
// Each record is one clock cycle: inputs, the expected combinational
// if_ready before the edge, and expected registered outputs after it.
module tb_decode_stage;

  logic          clock;
  logic          reset;
  logic [63:0]   IF_ID;
  logic          if_valid;
  logic          if_ready;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          ex_ready;
  logic [143:0]  ID_EX;
  logic          id_valid;
  logic [31:0]   stall_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  decode_stage #(.NREGS(32), .LOAD_OPCODE(7'b0000011), .PC_W(32)) dut (
    .clock(clock), .reset(reset), .IF_ID(IF_ID), .if_valid(if_valid),
    .if_ready(if_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ready(ex_ready), .ID_EX(ID_EX), .id_valid(id_valid),
    .stall_count(stall_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic          rst_n;
    logic          ifv;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          wbe;
    logic [4:0]    wba;
    logic [31:0]   wbd;
    logic          exr;
    logic          chk_rdy;
    logic          exp_rdy;
    logic          exp_vld;
    logic          chk_idex;
    logic [143:0]  exp_idex;
    logic [31:0]   exp_stall;
  } vec_t;

  function automatic logic [143:0] pk(input logic [31:0] pc, input logic [31:0] r1,
                                      input logic [31:0] r2, input logic [31:0] imm,
                                      input logic [4:0] rd, input logic [2:0] f3,
                                      input logic [6:0] op, input logic ld);
    return {ld, op, f3, rd, imm, r2, r1, pc};
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic ifv, input logic [31:0] pc,
                              input logic [31:0] instr, input logic wbe, input logic [4:0] wba,
                              input logic [31:0] wbd, input logic exr, input logic chk_rdy,
                              input logic exp_rdy, input logic exp_vld, input logic chk_idex,
                              input logic [143:0] exp_idex, input logic [31:0] exp_stall);
    vec_t v;
    v.rst_n = rst_n; v.ifv = ifv; v.pc = pc; v.instr = instr;
    v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.exr = exr;
    v.chk_rdy = chk_rdy; v.exp_rdy = exp_rdy; v.exp_vld = exp_vld;
    v.chk_idex = chk_idex; v.exp_idex = exp_idex; v.exp_stall = exp_stall;
    return v;
  endfunction

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clock);
    reset    = v.rst_n;
    if_valid = v.ifv;
    IF_ID    = {v.pc, v.instr};
    wb_en    = v.wbe;
    wb_addr  = v.wba;
    wb_data  = v.wbd;
    ex_ready = v.exr;
    #1;
    if (v.chk_rdy) check({tag, ".if_ready"}, {143'd0, if_ready}, {143'd0, v.exp_rdy});
    @(posedge clock);
    #1;
    check({tag, ".id_valid"}, {143'd0, id_valid}, {143'd0, v.exp_vld});
    if (v.chk_idex) check({tag, ".ID_EX"}, ID_EX, v.exp_idex);
    check({tag, ".stall_count"}, {112'd0, stall_count}, {112'd0, v.exp_stall});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[16];
  logic [143:0] e_ld3, e_addi2, e_x1, e_ldx12;

  initial begin
    reset = 1'b0; if_valid = 1'b0; IF_ID = '0; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; ex_ready = 1'b1;

    e_ld3 = pk(32'h14, 32'h0, 32'h0, 32'h0, 5'd3, 3'd2, 7'h03, 1'b1);
    e_x1  = pk(32'h28, 32'h0, 32'h0, 32'h0, 5'd1, 3'd0, 7'h13, 1'b0);

    // reset held two cycles with a write to x5 pending
    tbl[0]  = mk(0, 0, 32'h0,   32'h0,        1, 5'd5, 32'h1234, 1, 0, 0, 0, 1, '0, 0);
    tbl[1]  = mk(0, 0, 32'h0,   32'h0,        1, 5'd5, 32'h1234, 1, 0, 0, 0, 1, '0, 0);
    // addi x6,x5,0: x5 must read back cleared
    tbl[2]  = mk(1, 1, 32'h100, 32'h00028313, 0, 5'd0, 32'h0,    1, 1, 1, 1, 1,
                 pk(32'h100, 32'h0, 32'h0, 32'h0, 5'd6, 3'd0, 7'h13, 1'b0), 0);
    // write x1 = 0x10, nothing presented; ID_EX holds its last value
    tbl[3]  = mk(1, 0, 32'h0,   32'h0,        1, 5'd1, 32'h10,   1, 1, 1, 0, 1,
                 pk(32'h100, 32'h0, 32'h0, 32'h0, 5'd6, 3'd0, 7'h13, 1'b0), 0);
    // addi x1,x1,-1: sign-extended immediate
    tbl[4]  = mk(1, 1, 32'h4,   32'hFFF08093, 0, 5'd0, 32'h0,    1, 1, 1, 1, 1,
                 pk(32'h4, 32'h10, 32'h0, 32'hFFFFFFFF, 5'd1, 3'd0, 7'h13, 1'b0), 0);
    // addi x7,x3,5 with same-cycle write of x3 (bypass)
    tbl[5]  = mk(1, 1, 32'h8,   32'h00518393, 1, 5'd3, 32'hDEADBEEF, 1, 1, 1, 1, 1,
                 pk(32'h8, 32'hDEADBEEF, 32'h0, 32'h5, 5'd7, 3'd0, 7'h13, 1'b0), 0);
    // add x8,x0,x3 while writing 0x55 to x0: no bypass onto x0
    tbl[6]  = mk(1, 1, 32'hC,   32'h00300433, 1, 5'd0, 32'h55,   1, 1, 1, 1, 1,
                 pk(32'hC, 32'h0, 32'hDEADBEEF, 32'h3, 5'd8, 3'd0, 7'h33, 1'b0), 0);
    // addi x9,x0,0: x0 still reads zero afterwards
    tbl[7]  = mk(1, 1, 32'h10,  32'h00000493, 0, 5'd0, 32'h0,    1, 1, 1, 1, 1,
                 pk(32'h10, 32'h0, 32'h0, 32'h0, 5'd9, 3'd0, 7'h13, 1'b0), 0);
    // lw x3 then dependent addi x4,x3,0: one bubble, then accept
    tbl[8]  = mk(1, 1, 32'h14,  32'h00002183, 0, 5'd0, 32'h0,    1, 1, 1, 1, 1, e_ld3, 0);
    tbl[9]  = mk(1, 1, 32'h18,  32'h00018213, 0, 5'd0, 32'h0,    1, 1, 0, 0, 1, e_ld3, 1);
    tbl[10] = mk(1, 1, 32'h18,  32'h00018213, 0, 5'd0, 32'h0,    1, 1, 1, 1, 1,
                 pk(32'h18, 32'hDEADBEEF, 32'h0, 32'h0, 5'd4, 3'd0, 7'h13, 1'b0), 1);
    // lw x10 then add x11,x1,x10: hazard through rs2
    tbl[11] = mk(1, 1, 32'h1C,  32'h00002503, 0, 5'd0, 32'h0,    1, 1, 1, 1, 1,
                 pk(32'h1C, 32'h0, 32'h0, 32'h0, 5'd10, 3'd2, 7'h03, 1'b1), 1);
    tbl[12] = mk(1, 1, 32'h20,  32'h00A085B3, 0, 5'd0, 32'h0,    1, 1, 0, 0, 0, '0, 2);
    tbl[13] = mk(1, 1, 32'h20,  32'h00A085B3, 0, 5'd0, 32'h0,    1, 1, 1, 1, 1,
                 pk(32'h20, 32'h10, 32'h0, 32'hA, 5'd11, 3'd0, 7'h33, 1'b0), 2);
    // lw x0 followed by a reader of x0: rd==0 never hazards
    tbl[14] = mk(1, 1, 32'h24,  32'h00002003, 0, 5'd0, 32'h0,    1, 1, 1, 1, 1,
                 pk(32'h24, 32'h0, 32'h0, 32'h0, 5'd0, 3'd2, 7'h03, 1'b1), 2);
    tbl[15] = mk(1, 1, 32'h28,  32'h00000093, 0, 5'd0, 32'h0,    1, 1, 1, 1, 1, e_x1, 2);

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // back-pressure: hold addi x1 for three cycles, next instr waits
    for (int i = 0; i < 3; i++)
      run_vec(mk(1, 1, 32'h2C, 32'h00100113, 0, 5'd0, 32'h0, 0, 1, 0, 1, 1, e_x1, 2),
              $sformatf("hold%0d", i));
    e_addi2 = pk(32'h2C, 32'h0, 32'h10, 32'h1, 5'd2, 3'd0, 7'h13, 1'b0);
    run_vec(mk(1, 1, 32'h2C, 32'h00100113, 0, 5'd0, 32'h0, 1, 1, 1, 1, 1, e_addi2, 2), "release");

    // held load with a dependent instr waiting: no bubble counted while held
    e_ldx12 = pk(32'h30, 32'h0, 32'h0, 32'h0, 5'd12, 3'd2, 7'h03, 1'b1);
    run_vec(mk(1, 1, 32'h30, 32'h00002603, 0, 5'd0, 32'h0, 1, 1, 1, 1, 1, e_ldx12, 2), "ld_x12");
    for (int i = 0; i < 2; i++)
      run_vec(mk(1, 1, 32'h34, 32'h00060693, 0, 5'd0, 32'h0, 0, 1, 0, 1, 1, e_ldx12, 2),
              $sformatf("hold_hz%0d", i));
    run_vec(mk(1, 1, 32'h34, 32'h00060693, 0, 5'd0, 32'h0, 1, 1, 0, 0, 1, e_ldx12, 3), "bubble");

    // reset while the dependent instr is still presented
    run_vec(mk(0, 1, 32'h34, 32'h00060693, 1, 5'd7, 32'h99, 1, 0, 0, 0, 1, '0, 0), "mid_rst");
    // addi x13,x3,0 after reset: x3 cleared
    run_vec(mk(1, 1, 32'h34, 32'h00018693, 0, 5'd0, 32'h0, 1, 1, 1, 1, 1,
               pk(32'h34, 32'h0, 32'h0, 32'h0, 5'd13, 3'd0, 7'h13, 1'b0), 0), "resume");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
